// File: rtl/dpram_pkg.sv
// Shared types and helpers for the synchronous dual-port RAM.
// merge_bytes works at a fixed maximum width; callers size-cast in and out.
package dpram_pkg;

   typedef enum logic {
      CLR_IDLE,
      CLR_RUN
   } clear_state_e;

   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;

   localparam int MAX_DATA_W = 512;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] merge_bytes(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   mask
   );
      logic [MAX_DATA_W-1:0] result;
      result = old_word;
      for (int k = 0; k < MAX_BE_W; k++) begin
         if (mask[k]) result[8*k +: 8] = new_word[8*k +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-result delay line: RD_LATENCY stages of valid, data stages load only
// on valid so the last stage holds its value between results.
module dpram_rd_pipe #(
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [RD_LATENCY-1:0]             v_q;
   logic [RD_LATENCY-1:0][DATA_W-1:0] d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q[0] <= in_valid;
         if (in_valid) d_q[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) d_q[i] <= d_q[i-1];
         end
      end
   end

   assign out_valid = v_q[RD_LATENCY-1];
   assign out_data  = d_q[RD_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_sync.sv
// True dual-port RAM with synchronous, pipelined reads, defined collision
// rules and a sequential zero-sweep clear engine.
module dual_port_ram_sync
   import dpram_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int RD_LATENCY     = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [ADDR_W-1:0]   i_addr_a,
   input  logic [DATA_W-1:0]   i_wdata_a,
   input  logic [DATA_W/8-1:0] i_bmask_a,
   input  logic                i_wren_a,
   input  logic                i_rden_a,
   output logic [DATA_W-1:0]   o_rdata_a,
   output logic                o_rvalid_a,
   input  logic [ADDR_W-1:0]   i_addr_b,
   input  logic [DATA_W-1:0]   i_wdata_b,
   input  logic [DATA_W/8-1:0] i_bmask_b,
   input  logic                i_wren_b,
   input  logic                i_rden_b,
   output logic [DATA_W-1:0]   o_rdata_b,
   output logic                o_rvalid_b,
   input  logic                i_clear,
   output logic                o_busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "dual_port_ram_sync: RD_LATENCY must be 1 or 2");
   end
   if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
      $fatal(1, "dual_port_ram_sync: DATA_W must be a multiple of 8 within MAX_DATA_W");
   end

   clear_state_e      state, state_next;
   logic [ADDR_W-1:0] clr_cnt;
   logic              busy, addr_match, rd_a, rd_b;
   logic [BE_W-1:0]   lanes_a, lanes_b;
   logic [BE_W-1:0]   byp_aa, byp_ab, byp_ba, byp_bb;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= (CLEAR_ON_RESET != 0) ? CLR_RUN : CLR_IDLE;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLR_RUN) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         CLR_IDLE: if (i_clear) state_next = CLR_RUN;
         CLR_RUN:  if (&clr_cnt) state_next = CLR_IDLE;
         default:  state_next = CLR_IDLE;
      endcase
   end

   // Port gating while sweeping, plus write-first bypass lane selection.
   always_comb begin
      busy       = (state == CLR_RUN);
      rd_a       = i_rden_a && !busy;
      rd_b       = i_rden_b && !busy;
      lanes_a    = (i_wren_a && !busy) ? i_bmask_a : '0;
      lanes_b    = (i_wren_b && !busy) ? i_bmask_b : '0;
      addr_match = (i_addr_a == i_addr_b);
      byp_aa     = '0;
      byp_ab     = '0;
      byp_ba     = '0;
      byp_bb     = '0;
      if (RDW_MODE == RDW_WRITE_FIRST) begin
         byp_aa = lanes_a;
         byp_ab = addr_match ? lanes_b : '0;
         byp_ba = addr_match ? lanes_a : '0;
         byp_bb = lanes_b;
      end
   end

   assign o_busy = busy;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] old_a, old_b, wdata_a_q, wdata_b_q, word_a, word_b;
   logic [BE_W-1:0]   byp_aa_q, byp_ab_q, byp_ba_q, byp_bb_q;
   logic              rd_a_q, rd_b_q;

   // NOTE: the array has no reset; clearing is the sweep's job so it maps to block RAM.
   always_ff @(posedge i_clk) begin
      if (busy) begin
         mem[clr_cnt] <= '0;
      end else begin
         for (int k = 0; k < BE_W; k++) begin
            if (lanes_a[k]) mem[i_addr_a][8*k +: 8] <= i_wdata_a[8*k +: 8];
         end
         // Port B is written second so it owns lanes both ports enable.
         for (int k = 0; k < BE_W; k++) begin
            if (lanes_b[k]) mem[i_addr_b][8*k +: 8] <= i_wdata_b[8*k +: 8];
         end
      end
      old_a     <= mem[i_addr_a];
      old_b     <= mem[i_addr_b];
      wdata_a_q <= i_wdata_a;
      wdata_b_q <= i_wdata_b;
      byp_aa_q  <= byp_aa;
      byp_ab_q  <= byp_ab;
      byp_ba_q  <= byp_ba;
      byp_bb_q  <= byp_bb;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_a_q <= 1'b0;
         rd_b_q <= 1'b0;
      end else begin
         rd_a_q <= rd_a;
         rd_b_q <= rd_b;
      end
   end

   // Old word from the array, overlaid with A then B write lanes (B wins overlaps).
   assign word_a = DATA_W'(merge_bytes(
                      merge_bytes(MAX_DATA_W'(old_a), MAX_DATA_W'(wdata_a_q), MAX_BE_W'(byp_aa_q)),
                      MAX_DATA_W'(wdata_b_q), MAX_BE_W'(byp_ab_q)));
   assign word_b = DATA_W'(merge_bytes(
                      merge_bytes(MAX_DATA_W'(old_b), MAX_DATA_W'(wdata_a_q), MAX_BE_W'(byp_ba_q)),
                      MAX_DATA_W'(wdata_b_q), MAX_BE_W'(byp_bb_q)));

   dpram_rd_pipe #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_pipe_a (
      .clk       (i_clk),
      .rst       (i_reset),
      .in_valid  (rd_a_q),
      .in_data   (word_a),
      .out_valid (o_rvalid_a),
      .out_data  (o_rdata_a)
   );

   dpram_rd_pipe #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_pipe_b (
      .clk       (i_clk),
      .rst       (i_reset),
      .in_valid  (rd_b_q),
      .in_data   (word_b),
      .out_valid (o_rvalid_b),
      .out_data  (o_rdata_b)
   );

endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Two RAM configurations driven with identical stimulus and checked every
// cycle against a per-configuration behavioural model of the memory.
module tb_dual_port_ram_sync;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 2 ** AW;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic [1:0][AW-1:0] ad;
   logic [1:0][DW-1:0] wd;
   logic [1:0][BW-1:0] bm;
   logic [1:0]         we, rd;
   logic               clear;

   logic [1:0][DW-1:0] rdata_a, rdata_b;
   logic [1:0]         rvalid_a, rvalid_b, busy;

   always #5 clk = ~clk;

   // dut0: latency 1, write-first, clear on reset
   dual_port_ram_sync #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) dut0 (
      .i_clk(clk), .i_reset(reset),
      .i_addr_a(ad[0]), .i_wdata_a(wd[0]), .i_bmask_a(bm[0]), .i_wren_a(we[0]), .i_rden_a(rd[0]),
      .o_rdata_a(rdata_a[0]), .o_rvalid_a(rvalid_a[0]),
      .i_addr_b(ad[1]), .i_wdata_b(wd[1]), .i_bmask_b(bm[1]), .i_wren_b(we[1]), .i_rden_b(rd[1]),
      .o_rdata_b(rdata_b[0]), .o_rvalid_b(rvalid_b[0]),
      .i_clear(clear), .o_busy(busy[0])
   );

   // dut1: latency 2, read-first, no clear on reset
   dual_port_ram_sync #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(0)
   ) dut1 (
      .i_clk(clk), .i_reset(reset),
      .i_addr_a(ad[0]), .i_wdata_a(wd[0]), .i_bmask_a(bm[0]), .i_wren_a(we[0]), .i_rden_a(rd[0]),
      .o_rdata_a(rdata_a[1]), .o_rvalid_a(rvalid_a[1]),
      .i_addr_b(ad[1]), .i_wdata_b(wd[1]), .i_bmask_b(bm[1]), .i_wren_b(we[1]), .i_rden_b(rd[1]),
      .o_rdata_b(rdata_b[1]), .o_rvalid_b(rvalid_b[1]),
      .i_clear(clear), .o_busy(busy[1])
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat  [2];
   int mode [2];
   int cor  [2];

   logic [DW-1:0] ref_mem   [2][DEPTH];
   int            clr_left  [2];
   bit            due_v     [4][8];
   logic [DW-1:0] due_d     [4][8];
   logic [DW-1:0] last_data [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] apply_lanes(input logic [DW-1:0] w,
                                                 input logic [DW-1:0] n,
                                                 input logic [BW-1:0] m);
      for (int k = 0; k < BW; k++) if (m[k]) w[8*k +: 8] = n[8*k +: 8];
      return w;
   endfunction

   function automatic logic get_rv(input int d, input int p);
      return (p == 0) ? rvalid_a[d] : rvalid_b[d];
   endfunction

   function automatic logic [DW-1:0] get_rd(input int d, input int p);
      return (p == 0) ? rdata_a[d] : rdata_b[d];
   endfunction

   task automatic idle();
      we = '0; rd = '0; bm = '0; clear = 1'b0;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) clr_left[d] = (cor[d] != 0) ? DEPTH : 0;
      for (int i = 0; i < 4; i++) begin
         last_data[i] = '0;
         for (int s = 0; s < 8; s++) due_v[i][s] = 1'b0;
      end
   endtask

   // One clock edge: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         logic [DW-1:0] val;
         bit            busy_pre;
         busy_pre = (clr_left[d] > 0);
         if (!busy_pre) begin
            for (int p = 0; p < 2; p++) begin
               if (rd[p]) begin
                  val = ref_mem[d][ad[p]];
                  if (mode[d] == 0) begin
                     for (int w = 0; w < 2; w++)
                        if (we[w] && ad[w] == ad[p]) val = apply_lanes(val, wd[w], bm[w]);
                  end
                  due_v[d*2+p][(cyc + lat[d]) % 8] = 1'b1;
                  due_d[d*2+p][(cyc + lat[d]) % 8] = val;
               end
            end
            for (int w = 0; w < 2; w++)
               if (we[w]) ref_mem[d][ad[w]] = apply_lanes(ref_mem[d][ad[w]], wd[w], bm[w]);
            if (clear) clr_left[d] = DEPTH;
         end else begin
            ref_mem[d][DEPTH - clr_left[d]] = '0;
            clr_left[d]--;
         end
         for (int p = 0; p < 2; p++) begin
            bit exp_v;
            exp_v = due_v[d*2+p][cyc % 8];
            if (exp_v) last_data[d*2+p] = due_d[d*2+p][cyc % 8];
            due_v[d*2+p][cyc % 8] = 1'b0;
            check($sformatf("rvalid%0d_%0d", d, p), get_rv(d, p), exp_v);
            check($sformatf("rdata%0d_%0d", d, p), get_rd(d, p), last_data[d*2+p]);
         end
         check($sformatf("busy%0d", d), busy[d], clr_left[d] > 0);
      end
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_rvalid_a%0d", d), rvalid_a[d], 1'b0);
         check($sformatf("rst_rvalid_b%0d", d), rvalid_b[d], 1'b0);
         check($sformatf("rst_rdata_a%0d", d), rdata_a[d], '0);
         check($sformatf("rst_rdata_b%0d", d), rdata_b[d], '0);
         check($sformatf("rst_busy%0d", d), busy[d], cor[d] != 0);
      end
      model_reset();
      idle();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // Issue one read on port p, then let both configurations deliver it.
   task automatic read_port(input int p, input logic [AW-1:0] addr);
      idle();
      rd[p] = 1'b1;
      ad[p] = addr;
      step();
      idle();
      step();
      step();
   endtask

   initial begin
      int sw0, sw1, n;
      lat  = '{1, 2};
      mode = '{0, 1};
      cor  = '{1, 0};
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
      ad = '0; wd = '0;
      idle();
      @(posedge clk);
      #2;
      do_reset();

      // Sweep length, i_clear while sweeping, port traffic dropped while busy.
      sw0 = busy[0];
      sw1 = busy[1];
      for (int i = 0; i < 200; i++) begin
         idle();
         clear = (i < 6);
         if (i >= 1 && i <= DEPTH - 4) begin
            ad[0] = 2; wd[0] = 32'h5; bm[0] = '1; we[0] = 1'b1;
            ad[1] = AW'($urandom_range(0, DEPTH - 1));
            rd = 2'b11;
         end
         step();
         sw0 += busy[0];
         sw1 += busy[1];
         if (!busy[0] && !busy[1]) break;
      end
      idle();
      check("sweep_len0", sw0, DEPTH);
      check("sweep_len1", sw1, DEPTH);
      read_port(0, 2);
      check("busy_drop0", rdata_a[0], 32'h0);
      check("busy_drop1", rdata_a[1], 32'h0);

      // Reset-triggered clear wipes a stored word only where enabled.
      ad[0] = 3; wd[0] = 32'hDEADBEEF; bm[0] = '1; we[0] = 1'b1;
      step();
      idle();
      do_reset();
      n = 0;
      while (busy[0] && n < 100) begin
         step();
         n++;
      end
      check("clear_done", busy[0], 1'b0);
      check("clear_cycles", n, DEPTH);
      rd[0] = 1'b1; ad[0] = 3;
      step();
      idle();
      check("rv_at_n", rvalid_a[0], 1'b0);
      step();
      check("rv_at_n1", rvalid_a[0], 1'b1);
      step();
      check("rv_at_n2", rvalid_a[1], 1'b1);
      check("rst_clear0", rdata_a[0], 32'h0);
      check("rst_keep1", rdata_a[1], 32'hDEADBEEF);

      // Byte masks and read latency.
      ad[0] = 5'h10; wd[0] = 32'h11223344; bm[0] = 4'b1111; we[0] = 1'b1;
      step();
      wd[0] = 32'hAABBCCDD; bm[0] = 4'b0101;
      step();
      read_port(1, 5'h10);
      check("bmask0", rdata_b[0], 32'h11BB33DD);
      check("bmask1", rdata_b[1], 32'h11BB33DD);

      // Read during write on the same address.
      idle();
      ad[0] = 5; wd[0] = 32'h0; bm[0] = '1; we[0] = 1'b1;
      step();
      wd[0] = 32'hFFFFFFFF; bm[0] = 4'b0011;
      ad[1] = 5; rd[1] = 1'b1;
      step();
      idle();
      step();
      step();
      check("rdw_wfirst", rdata_b[0], 32'h0000FFFF);
      check("rdw_rfirst", rdata_b[1], 32'h00000000);

      // Write-write collision, resolved per lane.
      ad = '{5'd7, 5'd7};
      wd[0] = 32'h11111111; bm[0] = 4'b1100;
      wd[1] = 32'h22222222; bm[1] = 4'b0110;
      we = 2'b11;
      step();
      read_port(0, 7);
      check("wwcoll0", rdata_a[0], 32'h11222200);
      check("wwcoll1", rdata_a[1], 32'h11222200);

      // Random traffic concentrated on a few addresses to provoke collisions.
      for (int i = 0; i < 500; i++) begin
         for (int p = 0; p < 2; p++) begin
            ad[p] = AW'($urandom_range(0, 7));
            wd[p] = $urandom;
            bm[p] = BW'($urandom_range(0, 15));
            we[p] = ($urandom_range(0, 1) == 1);
            rd[p] = ($urandom_range(0, 1) == 1);
         end
         clear = ($urandom_range(0, 79) == 0);
         step();
      end
      idle();
      n = 0;
      while ((busy[0] || busy[1]) && n < 100) begin
         step();
         n++;
      end
      check("rand_idle", busy, 2'b00);

      // Reset with reads in flight.
      ad = '{5'd2, 5'd1};
      rd = 2'b11;
      step();
      step();
      do_reset();
      repeat (6) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dual_port_ram_sync.md
Name: dual_port_ram_sync

Overview:
Parametrised true dual-port RAM that succeeds the team's combinational-read dual-port memory.
- Reads are synchronous with a configurable pipeline latency and a per-port valid strobe.
- Read-during-write and write-write collisions follow defined rules.
- Clearing is done by a sequential clear engine, not a single-cycle array reset, so the array can map to block RAM.
- Sits between the core's instruction/data ports and backing storage.

Parameters:
ADDR_W, 16, word-address width; depth = 2**ADDR_W
DATA_W, 32, word width; multiple of 8; byte lanes BE_W = DATA_W/8
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, read-during-write to the same address: 0 = write-first (new data), 1 = read-first (old data)
CLEAR_ON_RESET, 1, 1 = start a clear sweep on reset release

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_addr_a  in  ADDR_W  port A word address
i_wdata_a  in  DATA_W  port A write data
i_bmask_a  in  BE_W  port A byte enables
i_wren_a  in  1  port A write strobe
i_rden_a  in  1  port A read strobe
o_rdata_a  out  DATA_W  port A read data
o_rvalid_a  out  1  port A read data valid
i_addr_b, i_wdata_b, i_bmask_b, i_wren_b, i_rden_b, o_rdata_b, o_rvalid_b: same as port A, for port B
i_clear  in  1  request a full-array zero sweep
o_busy  out  1  clear sweep in progress; port requests ignored

Behaviour:
Clocking and reset:
- Single clock domain (i_clk); asynchronous active-high reset i_reset.
- Reset values: o_rdata_a/b = 0, o_rvalid_a/b = 0, read pipelines flushed, clear counter = 0, o_busy = CLEAR_ON_RESET.
- The array itself is not reset.

Clear FSM:
- States: IDLE and CLEAR. Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
- In IDLE, i_clear=1 moves to CLEAR on the next edge.
- In CLEAR: write all-zero to word[cnt] each cycle, then cnt++. o_busy=1.
- When cnt = 2**ADDR_W-1, that zero write happens, then the FSM returns to IDLE next edge. o_busy falls the same edge; cnt wraps to 0.
- Sweep length is exactly 2**ADDR_W cycles.
- i_clear during CLEAR is ignored (no restart).
- Reset mid-sweep restarts per CLEAR_ON_RESET.

Port access while busy:
- While o_busy=1, port writes are dropped and rden is ignored; no rvalid results.
- Reads issued before busy rose still complete through the pipeline.

Writes:
- Byte lane k is written with wdata[8k+:8] when wren=1 and bmask[k]=1.
- A write with bmask = 0 has no effect.

Reads:
- rden=1 at edge N gives o_rdata and o_rvalid=1 at edge N+RD_LATENCY.
- Back-to-back reads give one result per cycle.
- When no result is due, o_rvalid=0 and o_rdata holds its last value.
- wren and rden may both be asserted on the same port.

Same-address read vs write (either port writing, either port reading, same cycle):
- RDW_MODE=0: enabled lanes return the new bytes; disabled lanes return the old bytes.
- RDW_MODE=1: all lanes return the old word.

Write-write collision (both ports write the same address):
- Resolved per lane: port B wins lanes both ports enable.
- Lanes enabled by only one port take that port's data.

Other rules:
- Address arithmetic is unsigned; no out-of-range addresses exist.
- RD_LATENCY outside {1,2} is a fatal elaboration error.
- DATA_W not a multiple of 8 is a fatal elaboration error.

Decomposition:
- Package dpram_pkg:
  - clear_state_e {CLR_IDLE, CLR_RUN}
  - RDW_WRITE_FIRST=0, RDW_READ_FIRST=1
  - byte-merge function merge_bytes(old, new, mask)
- One sub-module, dpram_rd_pipe (DATA_W, RD_LATENCY): valid/data delay line, instantiated once per port.
- Clear FSM and collision logic stay in the top module.

Test Plan:
- Reset-clear: ADDR_W=4, CLEAR_ON_RESET=1; preload word 3 = 0xDEADBEEF via backdoor, release reset -> o_busy high exactly 16 cycles; read word 3 -> 0x00000000, rvalid at N+1.
- Byte mask, latency: write A addr 0x10 = 0x11223344 with mask 4'b1111, then 0xAABBCCDD with mask 4'b0101; read B at edge N -> 0x11BB33DD at N+RD_LATENCY, for RD_LATENCY=1 and RD_LATENCY=2.
- Read-during-write: word 5 = 0x0; A writes 0xFFFFFFFF mask 4'b0011 while B reads 5 the same cycle -> RDW_MODE=0 gives 0x0000FFFF; RDW_MODE=1 gives 0x00000000.
- Write-write: A writes 0x11111111 mask 4'b1100, B writes 0x22222222 mask 4'b0110 to addr 7 -> readback 0x11222200.
- Busy blocking: i_clear in IDLE, then A writes 0x5 to addr 2 and rden during the sweep -> write dropped, no rvalid, addr 2 reads 0 afterward; i_clear mid-sweep leaves sweep length unchanged.
- Reset mid-operation: assert i_reset with reads in flight -> o_rvalid_a/b=0 and o_rdata_a/b=0 immediately (asynchronous); no stale rvalid after release.
